// File: rtl/tex_spi_pkg.sv
// Shared constants and state encoding for the texture SPI flash arbiter.
// Dual-output reads are selected at build time with the TEX_DUALIO_EN macro.
package tex_spi_pkg;

    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_DUAL_READ = 8'h3B;
    localparam int         DUMMY_CYCLES  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_DONE,
        ST_GAP
    } state_t;

endpackage

// File: rtl/tex_rr_arbiter.sv
// Two-way round-robin arbiter. A lone requester always wins; on a tie the
// requester that was not served last wins. The last-served pointer moves
// only when a grant is actually issued.
module tex_rr_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_req,
    input  logic       i_grantEn,
    output logic [1:0] o_gnt,
    output logic       o_id
);

    logic r_lastId;
    logic w_id;

    // Pick the winner from the request pattern and the last-served pointer
    always_comb begin
        w_id = 1'b0;
        if (i_req == 2'b10) begin
            w_id = 1'b1;
        end else if (i_req == 2'b11) begin
            w_id = ~r_lastId;
        end
        o_gnt = 2'b00;
        if (i_grantEn && (i_req != 2'b00)) begin
            o_gnt = w_id ? 2'b10 : 2'b01;
        end
    end

    assign o_id = w_id;

    // Remember who was served; reset so requester 0 wins the first tie
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lastId <= 1'b1;
        end else if (i_grantEn && (i_req != 2'b00)) begin
            r_lastId <= w_id;
        end
    end

endmodule

// File: rtl/tex_spi_arbiter.sv
// Shares one texture SPI flash between two texel requesters. Each grant runs
// one read (command, address, data) at clk/2 in SPI mode 0, then pulses the
// winner's ack with the fetched texel and keeps csb high for a short gap.
// Build option: TEX_DUALIO_EN selects the dual-output read (0x3B + dummy).
module tex_spi_arbiter
    import tex_spi_pkg::*;
#(
    parameter int ADDR_BITS = 24,
    parameter int DATA_BITS = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_enable,
    input  logic                 i_req0,
    input  logic [ADDR_BITS-1:0] i_addr0,
    output logic                 o_ack0,
    input  logic                 i_req1,
    input  logic [ADDR_BITS-1:0] i_addr1,
    output logic                 o_ack1,
    output logic [DATA_BITS-1:0] o_rdata,
    output logic                 o_busy,
    output logic                 o_tex_csb,
    output logic                 o_tex_sclk,
    output logic                 o_tex_out0,
    output logic                 o_tex_oeb0,
    input  logic [2:0]           i_tex_in
);

    localparam int TX_BITS = 8 + ADDR_BITS;

`ifdef TEX_DUALIO_EN
    localparam logic [7:0] CMD_BYTE   = CMD_DUAL_READ;
    localparam logic [7:0] DATA_LAST  = 8'(DATA_BITS / 2 - 1);
    localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);
`else
    localparam logic [7:0] CMD_BYTE   = CMD_READ;
    localparam logic [7:0] DATA_LAST  = 8'(DATA_BITS - 1);
`endif
    localparam logic [7:0] ADDR_LAST  = 8'(ADDR_BITS - 1);

    state_t               r_state;
    logic                 r_csb;
    logic                 r_sclk;
    logic [7:0]           r_cnt;
    logic [TX_BITS-1:0]   r_tx;
    logic [DATA_BITS-1:0] r_rx;
    logic [DATA_BITS-1:0] r_rdata;
    logic                 r_id;
    logic                 r_ack0;
    logic                 r_ack1;

    logic [1:0]           w_gnt;
    logic                 w_id;
    logic                 w_grantEn;
    logic [DATA_BITS-1:0] w_rxNext;
    logic                 w_unused;

    assign w_grantEn = (r_state == ST_IDLE) && i_enable;
    assign w_unused  = ^i_tex_in;

`ifdef TEX_DUALIO_EN
    logic r_oeb;
    assign w_rxNext   = DATA_BITS'({r_rx, i_tex_in[1], i_tex_in[0]});
    assign o_tex_oeb0 = r_oeb;
    assign o_tex_out0 = r_tx[TX_BITS-1] & ~r_oeb;

    // io[0] turns around to input from the start of the dummy phase until csb rises
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_oeb <= 1'b0;
        end else if (r_sclk && (r_cnt == 8'd0) && (r_state == ST_ADDR)) begin
            r_oeb <= 1'b1;
        end else if (r_sclk && (r_cnt == 8'd0) && (r_state == ST_DATA)) begin
            r_oeb <= 1'b0;
        end
    end
`else
    assign w_rxNext   = DATA_BITS'({r_rx, i_tex_in[1]});
    assign o_tex_oeb0 = 1'b0;
    assign o_tex_out0 = r_tx[TX_BITS-1];
`endif

    tex_rr_arbiter u_arb (
        .clk       (clk),
        .reset     (reset),
        .i_req     ({i_req1, i_req0}),
        .i_grantEn (w_grantEn),
        .o_gnt     (w_gnt),
        .o_id      (w_id)
    );

    assign o_busy     = (r_state != ST_IDLE);
    assign o_tex_csb  = r_csb;
    assign o_tex_sclk = r_sclk;
    assign o_ack0     = r_ack0;
    assign o_ack1     = r_ack1;
    assign o_rdata    = r_rdata;

    // Transaction sequencer: grant, shift out command/address on sclk falls, sample data, ack, gap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_csb   <= 1'b1;
            r_sclk  <= 1'b0;
            r_cnt   <= 8'd0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_rdata <= '0;
            r_id    <= 1'b0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt != 2'b00) begin
                        r_id    <= w_id;
                        r_tx    <= {CMD_BYTE, (w_id ? i_addr1 : i_addr0)};
                        r_csb   <= 1'b0;
                        r_sclk  <= 1'b0;
                        r_cnt   <= 8'd7;
                        r_state <= ST_CMD;
                    end
                end
                ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA: begin
                    if (!r_sclk) begin
                        r_sclk <= 1'b1;
                    end else begin
                        r_sclk <= 1'b0;
                        r_tx   <= {r_tx[TX_BITS-2:0], 1'b0};
                        r_cnt  <= r_cnt - 8'd1;
                        if (r_state == ST_DATA) begin
                            r_rx <= w_rxNext;
                        end
                        if (r_cnt == 8'd0) begin
                            case (r_state)
                                ST_CMD: begin
                                    r_state <= ST_ADDR;
                                    r_cnt   <= ADDR_LAST;
                                end
`ifdef TEX_DUALIO_EN
                                ST_ADDR: begin
                                    r_state <= ST_DUMMY;
                                    r_cnt   <= DUMMY_LAST;
                                end
                                ST_DUMMY: begin
                                    r_state <= ST_DATA;
                                    r_cnt   <= DATA_LAST;
                                end
`else
                                ST_ADDR: begin
                                    r_state <= ST_DATA;
                                    r_cnt   <= DATA_LAST;
                                end
`endif
                                default: begin
                                    r_state <= ST_DONE;
                                    r_csb   <= 1'b1;
                                    r_rdata <= w_rxNext;
                                    r_ack0  <= ~r_id;
                                    r_ack1  <= r_id;
                                end
                            endcase
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_GAP;
                    r_cnt   <= 8'd1;
                end
                ST_GAP: begin
                    if (r_cnt == 8'd0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tex_spi_arbiter.sv
// Self-checking bench for tex_spi_arbiter with a behavioural SPI flash model.
// Define TEX_DUALIO_EN for both RTL and bench to exercise the dual-output read.
module tb_tex_spi_arbiter;

`ifdef TEX_DUALIO_EN
   localparam logic [7:0] EXP_CMD    = 8'h3B;
   localparam int         DATA_START = 40;
   localparam int         DATA_SCLKS = 3;
   localparam int         EXP_OEB    = 64;
`else
   localparam logic [7:0] EXP_CMD    = 8'h03;
   localparam int         DATA_START = 32;
   localparam int         DATA_SCLKS = 6;
   localparam int         EXP_OEB    = -1;
`endif
   localparam int TOTAL_SCLK = DATA_START + DATA_SCLKS;
   localparam int LAT        = 2 * TOTAL_SCLK;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        i_enable = 1'b1;
   logic        i_req0 = 1'b0;
   logic        i_req1 = 1'b0;
   logic [23:0] i_addr0 = '0;
   logic [23:0] i_addr1 = '0;
   logic [2:0]  tin = 3'b000;
   logic        o_ack0, o_ack1, o_busy, o_tex_csb, o_tex_sclk, o_tex_out0, o_tex_oeb0;
   logic [5:0]  o_rdata;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   logic lastId = 1'b1;

   int          nRise = 0;
   logic [31:0] capBits = '0;
   logic [5:0]  txWord = '0;

   tex_spi_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .i_enable   (i_enable),
      .i_req0     (i_req0),
      .i_addr0    (i_addr0),
      .o_ack0     (o_ack0),
      .i_req1     (i_req1),
      .i_addr1    (i_addr1),
      .o_ack1     (o_ack1),
      .o_rdata    (o_rdata),
      .o_busy     (o_busy),
      .o_tex_csb  (o_tex_csb),
      .o_tex_sclk (o_tex_sclk),
      .o_tex_out0 (o_tex_out0),
      .o_tex_oeb0 (o_tex_oeb0),
      .i_tex_in   (tin)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // Cycle counter used for latency measurements
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Flash contents: two fixed texels and a hash elsewhere
   function automatic logic [5:0] flashWord(input logic [23:0] a);
      if (a == 24'h012345) return 6'b101101;
      if (a == 24'h000040) return 6'b110010;
      return a[5:0] ^ a[23:18] ^ 6'h2A;
   endfunction

   // Round-robin rule: a lone requester wins, a tie goes to the one not served last
   function automatic logic pickWinner(input logic r0, input logic r1, input logic last);
      if (r0 && r1) return ~last;
      return r1;
   endfunction

   // SPI flash model: captures MOSI on sclk rises, drives texel bits after sclk falls
   initial begin
      logic prevSclk;
      logic prevCsb;
      int   k;
      prevSclk = 1'b0;
      prevCsb  = 1'b1;
      forever begin
         @(negedge clk);
         if (prevCsb && !o_tex_csb) begin
            nRise = 0;
            tin   = 3'b000;
         end
         if (!o_tex_csb && !prevSclk && o_tex_sclk) begin
            if (nRise < 32) capBits = {capBits[30:0], o_tex_out0};
            nRise++;
            if (nRise == 32) txWord = flashWord(capBits[23:0]);
         end
         if (!o_tex_csb && prevSclk && !o_tex_sclk) begin
            k = nRise - DATA_START;
            if (k >= 0 && k < DATA_SCLKS) begin
`ifdef TEX_DUALIO_EN
               tin[1] = txWord[5-2*k];
               tin[0] = txWord[4-2*k];
`else
               tin[1] = txWord[5-k];
`endif
            end
         end
         prevSclk = o_tex_sclk;
         prevCsb  = o_tex_csb;
      end
   end

   // Single comparison point with failure accounting
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Wait for a grant, follow the whole read and check its timing, bus traffic and ack
   task automatic applyStimulus(input logic expId, input logic [23:0] expAddr,
                                input int dropAt, input int disableAt, output int waited);
      int n;
      int oebFirst;
      logic [5:0] held;
      logic toggleOk, heldOk, noBoth, oebOut0Ok, prevS;
      waited = 0;
      for (int w = 1; w <= 300; w++) begin
         @(posedge clk); #1;
         waited = w;
         if (!o_tex_csb) break;
      end
      checkOutput("grant_seen", {31'd0, o_tex_csb}, 32'd0);
      checkOutput("busy_at_grant", {31'd0, o_busy}, 32'd1);
      held = o_rdata;
      prevS = o_tex_sclk;
      toggleOk = 1'b1; heldOk = 1'b1; noBoth = 1'b1; oebOut0Ok = 1'b1;
      oebFirst = -1;
      for (n = 1; n <= 300; n++) begin
         @(posedge clk); #1;
         if (n == dropAt) begin i_req0 = 1'b0; i_req1 = 1'b0; end
         if (n == disableAt) i_enable = 1'b0;
         if (o_tex_sclk === prevS) toggleOk = 1'b0;
         prevS = o_tex_sclk;
         if (o_tex_oeb0 && oebFirst < 0) oebFirst = n;
         if (o_tex_oeb0 && o_tex_out0) oebOut0Ok = 1'b0;
         if (o_ack0 && o_ack1) noBoth = 1'b0;
         if (o_ack0 || o_ack1) break;
         if (o_rdata !== held) heldOk = 1'b0;
      end
      checkOutput("ack_latency", n, LAT);
      checkOutput("ack0", {31'd0, o_ack0}, {31'd0, ~expId});
      checkOutput("ack1", {31'd0, o_ack1}, {31'd0, expId});
      checkOutput("rdata", {26'd0, o_rdata}, {26'd0, flashWord(expAddr)});
      checkOutput("mosi_cmd_addr", capBits, {EXP_CMD, expAddr});
      checkOutput("sclk_count", nRise, TOTAL_SCLK);
      checkOutput("sclk_toggle", {31'd0, toggleOk}, 32'd1);
      checkOutput("oeb_start", oebFirst, EXP_OEB);
      checkOutput("out0_while_oeb", {31'd0, oebOut0Ok}, 32'd1);
      checkOutput("rdata_held", {31'd0, heldOk}, 32'd1);
      checkOutput("acks_exclusive", {31'd0, noBoth}, 32'd1);
      checkOutput("csb_done", {30'd0, o_tex_csb, o_tex_sclk}, 32'd2);
      @(posedge clk); #1;
      checkOutput("ack_pulse_end", {30'd0, o_ack1, o_ack0}, 32'd0);
      checkOutput("rdata_after", {26'd0, o_rdata}, {26'd0, flashWord(expAddr)});
   endtask

   // Bounded wait for the arbiter to drop back to IDLE
   task automatic waitIdle();
      for (int w = 0; w < 200; w++) begin
         if (!o_busy) break;
         @(posedge clk); #1;
      end
      checkOutput("idle_reached", {31'd0, o_busy}, 32'd0);
   endtask

   initial begin
      int          waited;
      int          t0, t1;
      logic        win, ok;
      logic [1:0]  pat;
      logic [23:0] a;

      // Asynchronous reset state
      #2 reset = 1'b1;
      #2;
      checkOutput("rst_csb", {31'd0, o_tex_csb}, 32'd1);
      checkOutput("rst_sclk", {31'd0, o_tex_sclk}, 32'd0);
      checkOutput("rst_out0_oeb0", {30'd0, o_tex_out0, o_tex_oeb0}, 32'd0);
      checkOutput("rst_acks", {30'd0, o_ack1, o_ack0}, 32'd0);
      checkOutput("rst_rdata", {26'd0, o_rdata}, 32'd0);
      checkOutput("rst_busy", {31'd0, o_busy}, 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk) reset = 1'b0;

      // Single reads from requester 0, including the fixed test texels
      $display("[TB] single reads");
      i_addr0 = 24'h012345; i_req0 = 1'b1;
      applyStimulus(1'b0, 24'h012345, 0, 0, waited);
      i_addr0 = 24'h000040;
      applyStimulus(1'b0, 24'h000040, 0, 0, waited);
      i_req0 = 1'b0;
      lastId = 1'b0;
      waitIdle();

      // Contention: both requesters held high, grants must alternate
      $display("[TB] contention");
      i_addr0 = 24'($urandom()); i_addr1 = 24'($urandom());
      i_req0 = 1'b1; i_req1 = 1'b1;
      t0 = -1;
      for (int t = 0; t < 4; t++) begin
         win = pickWinner(1'b1, 1'b1, lastId);
         applyStimulus(win, win ? i_addr1 : i_addr0, 0, 0, waited);
         t1 = cyc - 1 - LAT;
         if (t0 >= 0) checkOutput("grant_spacing", {31'd0, (t1 - t0) >= (LAT + 3)}, 32'd1);
         t0 = t1;
         lastId = win;
         if (win) i_addr1 = 24'($urandom()); else i_addr0 = 24'($urandom());
      end
      i_req0 = 1'b0; i_req1 = 1'b0;
      waitIdle();

      // Enable gating, then disabling mid-address still completes the read
      $display("[TB] enable gating");
      i_enable = 1'b0; i_addr1 = 24'($urandom()); i_req1 = 1'b1;
      ok = 1'b1;
      for (int c = 0; c < 100; c++) begin
         @(posedge clk); #1;
         if (!o_tex_csb || o_busy) ok = 1'b0;
      end
      checkOutput("gated_idle", {31'd0, ok}, 32'd1);
      i_enable = 1'b1;
      applyStimulus(1'b1, i_addr1, 0, 20, waited);
      checkOutput("grant_after_enable", waited, 1);
      lastId = 1'b1;
      i_req1 = 1'b0;
      i_enable = 1'b1;
      waitIdle();

      // Requester drops its request mid-read; ack still pulses, no further grant
      $display("[TB] requester drop");
      i_addr1 = 24'($urandom()); i_req1 = 1'b1;
      applyStimulus(1'b1, i_addr1, 10, 0, waited);
      lastId = 1'b1;
      ok = 1'b1;
      for (int c = 0; c < 50; c++) begin
         @(posedge clk); #1;
         if (!o_tex_csb) ok = 1'b0;
      end
      checkOutput("no_regrant", {31'd0, ok}, 32'd1);
      checkOutput("idle_after_drop", {31'd0, o_busy}, 32'd0);

      // Random request patterns against the round-robin rule
      $display("[TB] random trials");
      for (int t = 0; t < 6; t++) begin
         pat = 2'($urandom_range(1, 3));
         i_addr0 = 24'($urandom()); i_addr1 = 24'($urandom());
         i_req0 = pat[0]; i_req1 = pat[1];
         win = pickWinner(pat[0], pat[1], lastId);
         applyStimulus(win, win ? i_addr1 : i_addr0, 0, 0, waited);
         lastId = win;
         i_req0 = 1'b0; i_req1 = 1'b0;
         waitIdle();
      end

      // Asynchronous reset in the middle of the data phase
      $display("[TB] reset mid-data");
      a = 24'($urandom());
      i_addr0 = a; i_req0 = 1'b1;
      for (int w = 0; w < 300; w++) begin
         @(posedge clk); #1;
         if (!o_tex_csb) break;
      end
      repeat (LAT - 4) @(posedge clk);
      #4 reset = 1'b1;
      #1;
      checkOutput("midrst_csb_sclk", {30'd0, o_tex_csb, o_tex_sclk}, 32'd2);
      checkOutput("midrst_acks", {30'd0, o_ack1, o_ack0}, 32'd0);
      checkOutput("midrst_rdata", {26'd0, o_rdata}, 32'd0);
      checkOutput("midrst_busy", {31'd0, o_busy}, 32'd0);
      i_addr1 = 24'($urandom()); i_req1 = 1'b1;
      @(negedge clk) reset = 1'b0;
      lastId = 1'b1;
      win = pickWinner(1'b1, 1'b1, lastId);
      applyStimulus(win, i_addr0, 0, 0, waited);
      lastId = win;
      win = pickWinner(1'b1, 1'b1, lastId);
      applyStimulus(win, i_addr1, 0, 0, waited);
      i_req0 = 1'b0; i_req1 = 1'b0;
      waitIdle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/tex_spi_arbiter.md
Name: tex_spi_arbiter

Overview:
- Shares the single external texture SPI flash between two texel-fetch requesters (wall and floor/ceiling), arbitrating round-robin.
- Sequences one flash read per grant and returns the fetched texel to the winning requester.
- Sits between the rbzero texture requesters and the o_tex_csb/o_tex_sclk/o_tex_out0/o_tex_oeb0/i_tex_in pads.

Parameters:
- ADDR_BITS, 24, flash byte address width, sent MSB first.
- DATA_BITS, 6, texel bits read per transaction, MSB first; must be even.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high.
- i_enable  in  1  0 = grant no new transactions; an in-flight transaction completes.
- i_req0  in  1  requester 0 request; held high with address stable until its ack.
- i_addr0  in  ADDR_BITS  requester 0 address.
- o_ack0  out  1  one-cycle pulse; o_rdata valid.
- i_req1  in  1  requester 1 request.
- i_addr1  in  ADDR_BITS  requester 1 address.
- o_ack1  out  1  one-cycle pulse.
- o_rdata  out  DATA_BITS  last fetched texel; held until the next ack.
- o_busy  out  1  high in every state except IDLE.
- o_tex_csb  out  1  flash chip select, active low.
- o_tex_sclk  out  1  SPI clock, clk/2, mode 0.
- o_tex_out0  out  1  io[0] output (MOSI).
- o_tex_oeb0  out  1  io[0] direction; 0 = output.
- i_tex_in  in  3  io[2:0] inputs; io[1] is MISO.

Behaviour:
- Reset (async, immediate): csb=1, sclk=0, out0=0, oeb0=0, ack0=ack1=0, rdata=0, busy=0, RR pointer favours requester 0, state=IDLE.
- States: IDLE -> CMD (8 sclks) -> ADDR (ADDR_BITS sclks) -> DATA (DATA_BITS sclks) -> DONE (1 clk) -> GAP (2 clks) -> IDLE.
- IDLE: at an edge where i_enable=1 and any req is high, latch the winner's address and ID.
  - csb goes 0 after that edge (T0); state becomes CMD.
- Bit timing: each sclk period is 2 clks, low half then high half.
  - out0 changes only when sclk goes low.
  - Input is sampled at the clk edge that drives sclk from 1 to 0.
  - Single mode: command 0x03, then address, then DATA_BITS from i_tex_in[1].
- Completion: after the last data bit (edge T0+2*(8+ADDR_BITS+DATA_BITS) = T0+76 at defaults):
  - csb=1, sclk=0.
  - The winner's ack pulses for exactly 1 cycle in DONE, with o_rdata updated in the same cycle.
- GAP holds csb high for 2 clks minimum. The next grant edge is no earlier than T0+79.
- Arbitration:
  - Only one requester pending: it wins.
  - Both pending: the one not served last wins. After reset, the first tie goes to 0.
  - The RR pointer updates only at a grant.
- A req dropping mid-transaction does not abort it; the ack still pulses.
- A req still high in IDLE after its ack is a new request.
- i_enable falling mid-transaction: no effect until IDLE.
- Both acks are never high together. rdata is unchanged except at an ack.

Optional Feature:
- Macro: TEX_DUALIO_EN.
- Defined: dual-output read.
  - Command 0x3B, address, 8 dummy sclks (DUMMY state between ADDR and DATA), then DATA_BITS/2 sclks.
  - Each sample is {i_tex_in[1], i_tex_in[0]}, io[1] = MSB of the pair.
  - oeb0=1 from the first sclk-low of DUMMY until csb rises; out0=0 while oeb0=1.
  - Ack edge = T0+2*(8+ADDR_BITS+8+DATA_BITS/2) = T0+86 at defaults.
- Undefined: single-mode behaviour above; oeb0 is constantly 0; no DUMMY state.

Decomposition:
- Package tex_spi_pkg:
  - CMD_READ=8'h03 and CMD_DUAL_READ=8'h3B.
  - State enum (IDLE, CMD, ADDR, DUMMY, DATA, DONE, GAP).
  - DUMMY_CYCLES=8.
- Sub-module tex_rr_arbiter: 2-way round-robin.
  - Inputs req[1:0], grant_en.
  - Outputs one-hot gnt and the winner ID.
  - Owns the last-served pointer.
- The shift register, bit counter and sclk phase live in tex_spi_arbiter.

Test Plan:
- Single read: i_req0=1, addr0=24'h012345, flash model returns 6'b101101.
  - Required: MOSI shows 0x03 then 0x012345 MSB first, sclk toggles every clk.
  - Required: ack0 is a 1-cycle pulse at T0+76 with rdata=6'h2D; csb high at least 2 clks afterwards.
- Contention: req0 and req1 held continuously.
  - Required: grants alternate 0,1,0,1; each ack matches its own address; never both acks.
- Enable gating: i_enable=0 with req1=1.
  - Required: csb stays 1 and busy=0 for 100 cycles; i_enable=1 starts a grant at the next edge.
  - Required: clearing i_enable mid-ADDR still completes that read with ack.
- Async reset mid-DATA: reset asserted between clk edges.
  - Required: csb=1, sclk=0, acks=0, rdata=0 immediately.
  - Required: after release with both reqs high, requester 0 is granted first.
- Requester drop: req1 lowered at T0+10.
  - Required: transaction completes, ack1 pulses at T0+76, arbiter returns to IDLE with no further grant.
- TEX_DUALIO_EN: req0, addr0=24'h000040, model drives pairs 2'b11,2'b00,2'b10.
  - Required: MOSI shows 0x3B; oeb0 rises at the start of DUMMY.
  - Required: ack0 at T0+86 with rdata=6'b110010.
